// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline chains of the core.
package pipe_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int IFID_W    = 64;
  localparam int IDEX_W    = 128;
  localparam int EXMEM_W   = 96;
  localparam int MEMWB_W   = 96;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One chain slot: a valid bit plus payload, loaded on a move-in and cleared by kill.
module pipe_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             load_valid_i,
  input  logic             hold_i,
  input  logic             kill_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A held entry survives unless killed; a slot that neither loads nor holds empties.
  always_comb begin
    valid_d = 1'b0;
    data_d  = data_q;
    if (load_i) begin
      valid_d = load_valid_i;
      data_d  = data_i;
    end else if (hold_i) begin
      valid_d = ~kill_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/ready slots with bubble squeezing and per-slot flush.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  input  logic [DEPTH-1:0]         flush_mask,
  output logic [DEPTH-1:0]         slot_valid,
  output logic [occ_w(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0] valid_w;
  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH:0]   rdy;

  // Ready ripples from the output back; it deliberately ignores flush_mask.
  always_comb begin
    logic acc;
    acc        = out_ready;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = ~valid_w[i] | acc;
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             load, load_valid, hold;
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      // New input is never killed by flush_mask[0].
      assign load       = in_valid & rdy[0];
      assign load_valid = 1'b1;
      assign din        = in_data;
    end else begin : g_body
      assign load       = valid_w[i-1] & rdy[i];
      assign load_valid = ~flush_mask[i-1];
      assign din        = data_w[i-1];
    end

    assign hold = valid_w[i] & ~rdy[i+1];

    pipe_slot #(.WIDTH(WIDTH)) u_slot (
      .clk          (clk),
      .rst_n        (reset),
      .load_i       (load),
      .load_valid_i (load_valid),
      .hold_i       (hold),
      .kill_i       (flush_mask[i]),
      .data_i       (din),
      .valid_o      (valid_w[i]),
      .data_o       (data_w[i])
    );
  end

  assign in_ready   = rdy[0];
  assign out_valid  = valid_w[DEPTH-1] & ~flush_mask[DEPTH-1];
  assign out_data   = data_w[DEPTH-1];
  assign slot_valid = valid_w;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid_w[i]);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain against a position/gap reference model.
module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] flush_mask = '0;
  logic [DEPTH-1:0] slot_valid;
  logic [OCC_W-1:0] occupancy;

  pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .flush_mask (flush_mask),
    .slot_valid (slot_valid),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];

  // Reference model: which positions hold an entry, and what it carries.
  logic [DEPTH-1:0] mv = '0;
  logic [WIDTH-1:0] md [DEPTH];

  logic obs_in_ready, obs_out_valid;
  int   first_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // An entry at position p advances if any position >= p is free, or the consumer takes one.
  function automatic logic gap_above(input int p);
    for (int q = p; q < DEPTH; q++) if (!mv[q]) return 1'b1;
    return out_ready;
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      got_q.push_back(out_data);
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL out_data: got %0h expected nothing (scoreboard empty)", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+2: drive, check, advance the model across one clock edge.
  task automatic step(input logic iv, input logic [WIDTH-1:0] id,
                      input logic ordy, input logic [DEPTH-1:0] fm);
    logic [DEPTH-1:0] nv;
    logic [WIDTH-1:0] nd [DEPTH];
    in_valid = iv; in_data = id; out_ready = ordy; flush_mask = fm;
    #1;
    obs_in_ready  = in_ready;
    obs_out_valid = out_valid;
    chk("in_ready",   64'(in_ready),   64'(gap_above(0)));
    chk("out_valid",  64'(out_valid),  64'(mv[DEPTH-1] & ~fm[DEPTH-1]));
    chk("slot_valid", 64'(slot_valid), 64'(mv));
    chk("occupancy",  64'(occupancy),  64'($countones(mv)));
    nv = '0;
    for (int p = 0; p < DEPTH; p++) nd[p] = md[p];
    for (int p = 0; p < DEPTH; p++) begin
      if (mv[p]) begin
        if (gap_above(p + 1)) begin
          if (p == DEPTH - 1) begin
            if (!fm[p]) exp_q.push_back(md[p]);
          end else begin
            nv[p+1] = ~fm[p];
            nd[p+1] = md[p];
          end
        end else begin
          nv[p] = ~fm[p];
        end
      end
    end
    if (iv && gap_above(0)) begin
      nv[0] = 1'b1;
      nd[0] = id;
    end
    @(posedge clk); #2;
    mv = nv;
    for (int p = 0; p < DEPTH; p++) md[p] = nd[p];
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, '0, 1'b1, '0);
  endtask

  initial begin
    for (int p = 0; p < DEPTH; p++) md[p] = '0;
    reset = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b0;
    #1;
    chk("rst_out_valid",  64'(out_valid),  64'(0));
    chk("rst_slot_valid", 64'(slot_valid), 64'(0));
    chk("rst_occupancy",  64'(occupancy),  64'(0));
    chk("rst_out_data",   64'(out_data),   64'(0));
    chk("rst_in_ready",   64'(in_ready),   64'(1));
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ignore_in",  64'(occupancy),  64'(0));
    #1 reset = 1'b1;

    // Streaming at full rate.
    got_q.delete();
    first_out = -1;
    for (int k = 0; k < 12; k++) begin
      step(k < 8, WIDTH'(k + 1), 1'b1, '0);
      if (obs_out_valid && first_out < 0) first_out = k;
      if (k >= 4 && k <= 6) chk("occ_steady", 64'(occupancy), 64'(4));
    end
    drain();
    chk("latency", 64'(first_out), 64'(4));
    chk("stream_count", 64'(got_q.size()), 64'(8));
    for (int i = 0; i < got_q.size(); i++) chk("stream_order", 64'(got_q[i]), 64'(i + 1));

    // Fill with backpressure, then release one entry.
    got_q.delete();
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(32'hA0 + k), 1'b0, '0);
    step(1'b1, 32'hAF, 1'b0, '0);
    chk("full_in_ready", 64'(obs_in_ready), 64'(0));
    chk("full_occ", 64'(occupancy), 64'(4));
    step(1'b0, '0, 1'b1, '0);
    chk("release_in_ready", 64'(obs_in_ready), 64'(1));
    step(1'b0, '0, 1'b0, '0);
    chk("release_count", 64'(got_q.size()), 64'(1));
    drain();

    // Bubble squeeze.
    got_q.delete();
    step(1'b1, 32'hB1, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    step(1'b1, 32'hB2, 1'b0, '0);
    repeat (3) step(1'b0, '0, 1'b0, '0);
    chk("squeeze_slots", 64'(slot_valid), 64'(4'b1100));
    drain();
    chk("squeeze_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      chk("squeeze_first",  64'(got_q[0]), 64'(32'hB1));
      chk("squeeze_second", 64'(got_q[1]), 64'(32'hB2));
    end

    // Flush the two youngest while accepting E.
    got_q.delete();
    for (int k = 0; k < 4; k++) step(1'b1, WIDTH'(32'hC0 + k), 1'b0, '0);
    step(1'b1, 32'hCE, 1'b1, 4'b0011);
    chk("flush_in_ready", 64'(obs_in_ready), 64'(1));
    drain();
    chk("flush_count", 64'(got_q.size()), 64'(3));
    if (got_q.size() == 3) begin
      chk("flush_out0", 64'(got_q[0]), 64'(32'hC0));
      chk("flush_out1", 64'(got_q[1]), 64'(32'hC1));
      chk("flush_out2", 64'(got_q[2]), 64'(32'hCE));
    end

    // Kill the oldest while stalled.
    got_q.delete();
    for (int k = 0; k < 3; k++) step(1'b1, WIDTH'(32'hD0 + k), 1'b0, '0);
    step(1'b0, '0, 1'b0, '0);
    chk("stall_pre_occ", 64'(occupancy), 64'(3));
    step(1'b0, '0, 1'b0, 4'b1000);
    chk("stall_flush_out_valid", 64'(obs_out_valid), 64'(0));
    chk("stall_flush_occ", 64'(occupancy), 64'(2));
    chk("stall_flush_slots", 64'(slot_valid), 64'(4'b0110));
    drain();
    chk("stall_flush_count", 64'(got_q.size()), 64'(2));

    // Asynchronous reset with live entries.
    for (int k = 0; k < 3; k++) step(1'b1, WIDTH'(32'hE0 + k), 1'b0, '0);
    reset = 1'b0; in_valid = 1'b1;
    #1;
    chk("async_out_valid",  64'(out_valid),  64'(0));
    chk("async_occ",        64'(occupancy),  64'(0));
    chk("async_slot_valid", 64'(slot_valid), 64'(0));
    chk("async_in_ready",   64'(in_ready),   64'(1));
    chk("async_out_data",   64'(out_data),   64'(0));
    mv = '0;
    exp_q.delete();
    got_q.delete();
    @(posedge clk); @(posedge clk); #1;
    chk("async_hold_occ", 64'(occupancy), 64'(0));
    #1 reset = 1'b1;
    step(1'b1, 32'hAA, 1'b1, '0);
    drain();
    chk("post_rst_count", 64'(got_q.size()), 64'(1));
    if (got_q.size() > 0) chk("post_rst_first", 64'(got_q[0]), 64'(32'hAA));

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? DEPTH'($urandom) : '0);
    end
    drain();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
